// File: rtl/jk_counter_pkg.sv
// ============================================================================
// Module  : jk_counter_pkg
// Purpose : Shared JK-cell command encoding and next-state function.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package jk_counter_pkg;

  // Encoding matches {j,k} so a cell's inputs cast directly to a command.
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_SET    = 2'b10,
    JK_RESET  = 2'b01,
    JK_TOGGLE = 2'b11
  } jk_cmd_t;

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    jk_cmd_t cmd;
    cmd = jk_cmd_t'({j, k});
    case (cmd)
      JK_HOLD:  return q;
      JK_SET:   return 1'b1;
      JK_RESET: return 1'b0;
      default:  return ~q;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/jk_sync_counter_cell.sv
// ============================================================================
// Module  : jk_cell
// Purpose : Single JK flip-flop with synchronous active-high reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_cell
  import jk_counter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;

  always_ff @(posedge clk) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= jk_next(q_q, j, k);
  end

  assign q = q_q;

endmodule

`default_nettype wire

// File: rtl/jk_sync_counter.sv
// ============================================================================
// Module  : jk_sync_counter
// Purpose : Mod-MODULUS up/down counter built from jk_cell flops, with
//           clamped parallel load and combinational terminal count.
//           Define JK_COUNTER_SAT_EN for saturating instead of wrapping.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_sync_counter
  import jk_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] C_MAX   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   C_MOD_X = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] C_ONE   = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] nxt_d;
  logic             upd_d;
  logic             at_max, at_zero;

  assign at_max  = (count_q == C_MAX);
  assign at_zero = (count_q == '0);

  always_comb begin
    nxt_d = count_q;
    upd_d = 1'b0;
    if (load) begin
      upd_d = 1'b1;
      nxt_d = ({1'b0, load_val} >= C_MOD_X) ? C_MAX : load_val;
    end else if (en) begin
      upd_d = 1'b1;
`ifdef JK_COUNTER_SAT_EN
      if (up) nxt_d = at_max  ? C_MAX : count_q + C_ONE;
      else    nxt_d = at_zero ? '0    : count_q - C_ONE;
`else
      if (up) nxt_d = at_max  ? '0    : count_q + C_ONE;
      else    nxt_d = at_zero ? C_MAX : count_q - C_ONE;
`endif
    end
  end

  // Updating cells are forced to set/reset; idle cells see j=k=0 and hold.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (upd_d &  nxt_d[i]),
      .k   (upd_d & ~nxt_d[i]),
      .q   (count_q[i])
    );
  end

  assign count = count_q;
  assign tc    = en & ~load & ~rst & (up ? at_max : at_zero);

endmodule

`default_nettype wire

// File: tb/tb_jk_sync_counter.sv
// ============================================================================
// Module  : tb_jk_sync_counter
// Purpose : Directed and random checks of jk_sync_counter (WIDTH=4, MODULUS=10)
//           against an arithmetic reference model. Honors JK_COUNTER_SAT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jk_sync_counter;
  import jk_counter_pkg::*;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic         up  = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count;
  logic         tc;

  int n_checks = 0;
  int n_fail   = 0;
  int model    = 0;

  always #5 clk = ~clk;

  jk_sync_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc)
  );

  function automatic int model_next(int c, bit r, bit e, bit u, bit l, int lv);
    if (r) return 0;
    if (l) return (lv >= M) ? M - 1 : lv;
    if (!e) return c;
`ifdef JK_COUNTER_SAT_EN
    if (u) return (c == M - 1) ? c : c + 1;
    return (c == 0) ? 0 : c - 1;
`else
    if (u) return (c + 1) % M;
    return (c + M - 1) % M;
`endif
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check tc before the edge, then count after it.
  task automatic cyc(input bit r, input bit e, input bit u, input bit l, input int lv);
    logic exp_tc;
    rst = r; en = e; up = u; load = l; load_val = W'(lv);
    #1;
    exp_tc = e && !l && !r && (u ? (model == M - 1) : (model == 0));
    check("tc", {3'b0, tc}, {3'b0, exp_tc});
    @(posedge clk);
    model = model_next(model, r, e, u, l, lv);
    #1;
    check("count", count, W'(model));
  endtask

  initial begin
    // jk_next truth table
    check("jk_hold0", {3'b0, jk_next(1'b0, 1'b0, 1'b0)}, 4'd0);
    check("jk_hold1", {3'b0, jk_next(1'b1, 1'b0, 1'b0)}, 4'd1);
    check("jk_set",   {3'b0, jk_next(1'b0, 1'b1, 1'b0)}, 4'd1);
    check("jk_reset", {3'b0, jk_next(1'b1, 1'b0, 1'b1)}, 4'd0);
    check("jk_tog",   {3'b0, jk_next(1'b1, 1'b1, 1'b1)}, 4'd0);

    @(negedge clk);
    // 1. reset with en/up active
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    check("rst_count_lit", count, 4'd0);

    // 2. count up 12 cycles: 1..9,0,1,2
    for (int i = 0; i < 12; i++) cyc(0, 1, 1, 0, 0);
    check("up12_lit", count, 4'd2);

    // 3. count down from 0
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
`ifdef JK_COUNTER_SAT_EN
    check("down3_lit", count, 4'd0);
`else
    check("down3_lit", count, 4'd7);
`endif

    // 4. clamped load, then load with en=0
    cyc(0, 1, 1, 1, 13);
    check("load13_lit", count, 4'd9);
    cyc(0, 0, 0, 1, 5);
    check("load5_lit", count, 4'd5);

    // 5. reset beats load and step
    cyc(0, 0, 0, 1, 7);
    cyc(1, 1, 1, 1, 3);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
    check("hold0_lit", count, 4'd0);

    // 6. random traffic, including illegal load values
    for (int i = 0; i < 1000; i++) begin
      cyc(($urandom_range(0, 49) == 0), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
          ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
